// File: rtl/lc3_mem_sequencer.sv
// LC-3 data memory access sequencer.
// Walks LD/ST and their indirect forms through IND/RD/WR memory phases.
module lc3_mem_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] M_Addr,
    input  logic [15:0] M_Data,
    input  logic [15:0] DMem_dout,
    output logic [15:0] DMem_addr,
    output logic [15:0] DMem_din,
    output logic        DMem_rd,
    output logic        DMem_we,
    output logic [1:0]  mem_state,
    output logic [15:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        overlap_err
);

    typedef enum logic [1:0] {
        IDLE,
        IND,
        RD,
        WR
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [15:0] ind_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (op[1]) begin
                        state_nx = IND;
                    end else if (op[0]) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            IND:     state_nx = op_q[0] ? WR : RD;
            RD:      state_nx = IDLE;
            WR:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        DMem_addr = 16'h0000;
        DMem_din  = 16'h0000;
        DMem_rd   = 1'b0;
        DMem_we   = 1'b0;
        mem_state = 2'd3;
        unique case (state)
            IDLE: mem_state = 2'd3;
            IND: begin
                mem_state = 2'd2;
                DMem_addr = addr_q;
                DMem_rd   = 1'b1;
            end
            RD: begin
                mem_state = 2'd0;
                DMem_addr = (op_q == 2'b10) ? ind_q : addr_q;
                DMem_rd   = 1'b1;
            end
            WR: begin
                mem_state = 2'd1;
                DMem_addr = (op_q == 2'b11) ? ind_q : addr_q;
                DMem_din  = data_q;
                DMem_we   = 1'b1;
            end
            default: mem_state = 2'd3;
        endcase
    end

    assign busy = (state != IDLE);

    // Request registers only load on acceptance; starts while busy are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q        <= 2'b00;
            addr_q      <= 16'h0000;
            data_q      <= 16'h0000;
            ind_q       <= 16'h0000;
            load_data   <= 16'h0000;
            done        <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_q   <= op;
                addr_q <= M_Addr;
                data_q <= M_Data;
            end
            if (state == IND) begin
                ind_q <= DMem_dout;
            end
            if (state == RD) begin
                load_data <= DMem_dout;
            end
            done <= (state == RD) || (state == WR);
            if (start && state != IDLE) begin
                overlap_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Self-checking bench for lc3_mem_sequencer.
// Directed table vectors, corner sequences and a randomized transaction model.
module tb_lc3_mem_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic [15:0] DMem_dout;
    logic [15:0] DMem_addr;
    logic [15:0] DMem_din;
    logic        DMem_rd;
    logic        DMem_we;
    logic [1:0]  mem_state;
    logic [15:0] load_data;
    logic        busy;
    logic        done;
    logic        overlap_err;

    lc3_mem_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .M_Addr      (M_Addr),
        .M_Data      (M_Data),
        .DMem_dout   (DMem_dout),
        .DMem_addr   (DMem_addr),
        .DMem_din    (DMem_din),
        .DMem_rd     (DMem_rd),
        .DMem_we     (DMem_we),
        .mem_state   (mem_state),
        .load_data   (load_data),
        .busy        (busy),
        .done        (done),
        .overlap_err (overlap_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  ms;
        logic        rd;
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
    } acc_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] p_a;
        logic [15:0] p_v;
        logic [15:0] q_a;
        logic [15:0] q_v;
        acc_t        e0;
        acc_t        e1;
        int          n;
        logic        is_ld;
        logic [15:0] ld;
    } vec_t;

    // env_mem follows what the DUT actually writes; ref_mem follows the model.
    logic [15:0] env_mem [65536];
    logic [15:0] ref_mem [65536];
    assign DMem_dout = env_mem[DMem_addr];

    int          errors = 0;
    int          checks = 0;
    logic        exp_done;
    logic        exp_ovl;
    logic [15:0] exp_load;
    logic [15:0] pool [8];
    vec_t        vecs [4];

    function automatic acc_t mk(logic [1:0] ms, logic rd, logic we,
                                logic [15:0] a, logic [15:0] d);
        acc_t r;
        r.ms = ms;
        r.rd = rd;
        r.we = we;
        r.addr = a;
        r.din = d;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_acc(string tag, acc_t e, logic be, logic de);
        chk({tag, ".mem_state"}, 32'(mem_state), 32'(e.ms));
        chk({tag, ".rd"}, 32'(DMem_rd), 32'(e.rd));
        chk({tag, ".we"}, 32'(DMem_we), 32'(e.we));
        chk({tag, ".addr"}, 32'(DMem_addr), 32'(e.addr));
        chk({tag, ".din"}, 32'(DMem_din), 32'(e.din));
        chk({tag, ".busy"}, 32'(busy), 32'(be));
        chk({tag, ".done"}, 32'(done), 32'(de));
        chk({tag, ".ovl"}, 32'(overlap_err), 32'(exp_ovl));
    endtask

    task automatic tick();
        logic        w;
        logic [15:0] wa;
        logic [15:0] wd;
        w = DMem_we;
        wa = DMem_addr;
        wd = DMem_din;
        @(posedge clock);
        if (w === 1'b1) env_mem[wa] = wd;
        @(negedge clock);
    endtask

    task automatic idle_chk(string tag);
        chk_acc(tag, mk(2'd3, 1'b0, 1'b0, 16'h0, 16'h0), 1'b0, exp_done);
        chk({tag, ".load"}, 32'(load_data), 32'(exp_load));
    endtask

    task automatic gap();
        idle_chk("gap");
        start = 1'b0;
        op = 2'($urandom);
        M_Addr = 16'($urandom);
        tick();
        exp_done = 1'b0;
    endtask

    task automatic preload(logic [15:0] a, logic [15:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Expected access trace of one operation, from the op semantics alone.
    task automatic model(input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] d, output acc_t e0,
                         output acc_t e1, output int n,
                         output logic is_ld, output logic [15:0] ld);
        logic [15:0] p;
        p = ref_mem[a];
        e1 = mk(2'd3, 1'b0, 1'b0, 16'h0, 16'h0);
        ld = 16'h0;
        is_ld = ~o[0];
        case (o)
            2'b00: begin n = 1; e0 = mk(2'd0, 1, 0, a, 0); ld = ref_mem[a]; end
            2'b01: begin n = 1; e0 = mk(2'd1, 0, 1, a, d); end
            2'b10: begin
                n = 2;
                e0 = mk(2'd2, 1, 0, a, 0);
                e1 = mk(2'd0, 1, 0, p, 0);
                ld = ref_mem[p];
            end
            default: begin
                n = 2;
                e0 = mk(2'd2, 1, 0, a, 0);
                e1 = mk(2'd1, 0, 1, p, d);
            end
        endcase
    endtask

    task automatic run_txn(string tag, logic [1:0] o, logic [15:0] a,
                           logic [15:0] d, acc_t e0, acc_t e1, int n,
                           logic is_ld, logic [15:0] ld,
                           int ovl_k, int rst_k);
        acc_t e;
        idle_chk({tag, ".idle"});
        start = 1'b1;
        op = o;
        M_Addr = a;
        M_Data = d;
        tick();
        exp_done = 1'b0;
        for (int k = 0; k < n; k++) begin
            e = (k == 0) ? e0 : e1;
            chk_acc($sformatf("%s.acc%0d", tag, k), e, 1'b1, 1'b0);
            if (e.we) ref_mem[e.addr] = e.din;
            start = 1'b0;
            op = 2'($urandom);
            M_Addr = 16'($urandom);
            M_Data = 16'($urandom);
            if (k == ovl_k || k == rst_k) start = 1'b1;
            if (k == rst_k) reset = 1'b1;
            tick();
            start = 1'b0;
            if (reset) begin
                reset = 1'b0;
                exp_ovl = 1'b0;
                exp_load = 16'h0;
                return;
            end
            if (k == ovl_k) exp_ovl = 1'b1;
        end
        if (is_ld) exp_load = ld;
        exp_done = 1'b1;
    endtask

    initial begin
        acc_t        e0;
        acc_t        e1;
        int          n;
        logic        is_ld;
        logic [15:0] ld;
        logic [1:0]  o;
        logic [15:0] a;
        logic [15:0] d;
        int          ovl_k;
        int          rst_k;

        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 16'(i) ^ 16'h3C5A;
            ref_mem[i] = 16'(i) ^ 16'h3C5A;
        end
        pool = '{16'h0000, 16'hFFFF, 16'h3010, 16'h3020,
                 16'h4000, 16'h5000, 16'h8001, 16'h7FFE};

        vecs[0] = '{2'b00, 16'h3010, 16'h0000, 16'h3010, 16'h1234,
                    16'h0001, 16'h0001,
                    mk(2'd0, 1, 0, 16'h3010, 16'h0), mk(2'd3, 0, 0, 0, 0),
                    1, 1'b1, 16'h1234};
        vecs[1] = '{2'b01, 16'h4000, 16'hBEEF, 16'h0002, 16'h0002,
                    16'h0003, 16'h0003,
                    mk(2'd1, 0, 1, 16'h4000, 16'hBEEF), mk(2'd3, 0, 0, 0, 0),
                    1, 1'b0, 16'h0000};
        vecs[2] = '{2'b10, 16'h3020, 16'h0000, 16'h3020, 16'h5000,
                    16'h5000, 16'hA5A5,
                    mk(2'd2, 1, 0, 16'h3020, 16'h0),
                    mk(2'd0, 1, 0, 16'h5000, 16'h0),
                    2, 1'b1, 16'hA5A5};
        vecs[3] = '{2'b11, 16'h3030, 16'h0F0F, 16'h3030, 16'h6000,
                    16'h0004, 16'h0004,
                    mk(2'd2, 1, 0, 16'h3030, 16'h0),
                    mk(2'd1, 0, 1, 16'h6000, 16'h0F0F),
                    2, 1'b0, 16'h0000};

        reset = 1'b1;
        start = 1'b1;
        op = 2'b10;
        M_Addr = 16'h1111;
        M_Data = 16'h2222;
        exp_done = 1'b0;
        exp_ovl = 1'b0;
        exp_load = 16'h0;
        @(negedge clock);
        tick();
        tick();
        idle_chk("reset");
        reset = 1'b0;
        start = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            preload(vecs[i].p_a, vecs[i].p_v);
            preload(vecs[i].q_a, vecs[i].q_v);
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                    vecs[i].d, vecs[i].e0, vecs[i].e1, vecs[i].n,
                    vecs[i].is_ld, vecs[i].ld, -1, -1);
            gap();
        end
        chk("sti.ptr_kept", 32'(env_mem[16'h3030]), 32'h6000);
        chk("sti.target", 32'(env_mem[16'h6000]), 32'h0F0F);

        preload(16'h3020, 16'h5000);
        preload(16'h5000, 16'hA5A5);
        run_txn("ldi_ovl", 2'b10, 16'h3020, 16'h0,
                vecs[2].e0, vecs[2].e1, 2, 1'b1, 16'hA5A5, 0, -1);
        run_txn("b2b_st", 2'b01, 16'hFFFF, 16'h1357,
                mk(2'd1, 0, 1, 16'hFFFF, 16'h1357), mk(2'd3, 0, 0, 0, 0),
                1, 1'b0, 16'h0, -1, -1);
        gap();

        preload(16'h3030, 16'h6000);
        preload(16'h6000, 16'h0000);
        run_txn("sti_rst", 2'b11, 16'h3030, 16'h0F0F,
                vecs[3].e0, vecs[3].e1, 2, 1'b0, 16'h0, -1, 0);
        for (int i = 0; i < 3; i++) gap();
        chk("sti_rst.no_write", 32'(env_mem[16'h6000]), 32'h0000);

        for (int t = 0; t < 200; t++) begin
            o = 2'($urandom);
            a = pool[$urandom_range(0, 7)];
            d = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)]
                                             : 16'($urandom);
            model(o, a, d, e0, e1, n, is_ld, ld);
            ovl_k = -1;
            rst_k = -1;
            if ($urandom_range(0, 14) == 0) begin
                rst_k = $urandom_range(0, n - 1);
            end else if ($urandom_range(0, 5) == 0) begin
                ovl_k = $urandom_range(0, n - 1);
            end
            run_txn("rnd", o, a, d, e0, e1, n, is_ld, ld, ovl_k, rst_k);
            if ($urandom_range(0, 2) == 0) gap();
        end
        gap();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mem%0d", i), 32'(env_mem[pool[i]]),
                32'(ref_mem[pool[i]]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_sequencer.md
LC3_MEM_SEQUENCER -- requirements
Module: lc3_mem_sequencer

Interface
REQ-001 clock  input  1  single clock for the block; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 start  input  1  request pulse; samples op, M_Addr and M_Data when accepted.
REQ-004 op  input  2  operation: 00 LD/LDR read, 01 ST/STR write, 10 LDI indirect read, 11 STI indirect write.
REQ-005 M_Addr  input  16  effective address from execute stage.
REQ-006 M_Data  input  16  store data from execute stage.
REQ-007 DMem_dout  input  16  data memory read data; combinational, valid in the same cycle as DMem_addr.
REQ-008 DMem_addr  output  16  data memory address.
REQ-009 DMem_din  output  16  data memory write data.
REQ-010 DMem_rd  output  1  data memory read strobe, active high.
REQ-011 DMem_we  output  1  data memory write strobe, active high.
REQ-012 mem_state  output  2  access phase: 0 read, 1 write, 2 indirect-address read, 3 idle.
REQ-013 load_data  output  16  last read result (LD/LDR/LDI); holds until next read completes.
REQ-014 busy  output  1  high while an operation is in progress (state not IDLE).
REQ-015 done  output  1  one-cycle pulse on completion of an operation.
REQ-016 overlap_err  output  1  sticky flag: start seen while busy.

Function
REQ-017 FSM states IDLE, IND, RD, WR; mem_state = 3, 2, 0, 1 respectively, combinationally decoded from state.
REQ-018 IDLE + start: register op/M_Addr/M_Data into op_q/addr_q/data_q; next state IND if op[1]=1, RD if op=00, WR if op=01.
REQ-019 IND: DMem_addr=addr_q, DMem_rd=1, DMem_we=0; capture DMem_dout into ind_q; next RD if op_q=10, WR if op_q=11.
REQ-020 RD: DMem_addr = ind_q if op_q=10, else addr_q; DMem_rd=1; load_data <= DMem_dout at end of cycle; next IDLE.
REQ-021 WR: DMem_addr = ind_q if op_q=11, else addr_q; DMem_din=data_q; DMem_we=1 for exactly one cycle; next IDLE.
REQ-022 IDLE outputs: DMem_addr=0, DMem_din=0, DMem_rd=0, DMem_we=0; DMem_din=0 in IND and RD.
REQ-023 DMem_rd and DMem_we never both high in the same cycle.
REQ-024 done registered: high exactly in the cycle after RD or WR (state back in IDLE), low otherwise.
REQ-025 Latency: start accepted at cycle T -> direct op access at T+1, done at T+2; indirect op accesses at T+1 and T+2, done at T+3.
REQ-026 start while busy: ignored (no state/register change), overlap_err set to 1 and held until reset.
REQ-027 start in cycle done=1: accepted normally (back-to-back, no bubble beyond IDLE cycle).
REQ-028 Address arithmetic: none; addresses pass unmodified, 16-bit, x0000 and xFFFF legal.
REQ-029 busy = (state != IDLE), combinational.

Reset
REQ-030 reset: state=IDLE, op_q/addr_q/data_q/ind_q/load_data=0, done=0, overlap_err=0; reset dominates start.
REQ-031 reset mid-operation (any of IND/RD/WR): no further access issued, DMem_we=0 from the next cycle, done not asserted for the aborted op.

Verification
REQ-032 LD: start, op=00, M_Addr=x3010, mem[x3010]=x1234 -> T+1 mem_state=0, DMem_rd=1, DMem_addr=x3010; T+2 done=1, load_data=x1234.
REQ-033 ST: op=01, M_Addr=x4000, M_Data=xBEEF -> T+1 mem_state=1, DMem_we=1, DMem_addr=x4000, DMem_din=xBEEF; T+2 done=1.
REQ-034 LDI: op=10, M_Addr=x3020, mem[x3020]=x5000, mem[x5000]=xA5A5 -> T+1 mem_state=2 addr x3020; T+2 mem_state=0 addr x5000; T+3 done=1, load_data=xA5A5.
REQ-035 STI: op=11, M_Addr=x3030, mem[x3030]=x6000, M_Data=x0F0F -> T+2 DMem_we=1, DMem_addr=x6000, DMem_din=x0F0F; mem[x3030] unchanged.
REQ-036 start at T+1 of an LDI -> ignored, overlap_err=1, LDI completes at T+3; start in done cycle accepted, next access one cycle later.
REQ-037 reset asserted during STI IND cycle -> DMem_we never asserts, all outputs at reset values, mem_state=3, done=0.
